// File: rtl/atanh_input_conditioner.sv
// atanh_input_conditioner: front end of cordic_tanh_inverse.
// Buffers raw signed Q4.16 samples in a small FIFO and saturates each one
// into the atanh domain (-1,1) as it is written. The stage then issues one
// sample per cycle on the CORDIC y_input bus. A valid/clamp delay line is
// matched to the CORDIC latency, so res_valid/res_clamped line up with z_res.
// Optional feature: define ATANH_COND_STATS_EN to enable the saturating
// clamped-sample counter on ovr_cnt (otherwise ovr_cnt is tied to zero).
module atanh_input_conditioner #(
  parameter int          DEPTH   = 4,
  parameter int          LATENCY = 16,
  parameter logic [19:0] YMAX    = 20'h0FFBE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [19:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   issue_en,
  input  logic                   flush,
  output logic [19:0]            y_out,
  output logic                   y_valid,
  output logic                   res_valid,
  output logic                   res_clamped,
  output logic [7:0]             ovr_cnt,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [19:0]   POS_ONE  = 20'h10000;
  localparam logic [19:0]   NEG_ONE  = 20'hF0000;
  localparam logic [19:0]   NEG_YMAX = ~YMAX + 20'd1;

  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          y_clamp;
  logic [1:0]    dly [LATENCY];

  logic          do_push;
  logic          do_pop;
  logic          in_clamp;
  logic [19:0]   in_sat;

  assign in_ready = (occ != FULL);
  assign count    = occ;

  // Flush wins over any same-cycle push or pop, so both are masked here.
  assign do_push = in_valid & in_ready & ~flush;
  assign do_pop  = issue_en & (occ != '0) & ~flush;

  // Saturate the incoming sample into (-1,1); exactly +/-YMAX passes untouched.
  always_comb begin
    in_clamp = 1'b0;
    in_sat   = in_data;
    if ($signed(in_data) >= $signed(POS_ONE)) begin
      in_clamp = 1'b1;
      in_sat   = YMAX;
    end else if ($signed(in_data) <= $signed(NEG_ONE)) begin
      in_clamp = 1'b1;
      in_sat   = NEG_YMAX;
    end
  end

  // FIFO storage holds {clamp flag, conditioned data}; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {in_clamp, in_sat};
    end
  end

  // Pointers, occupancy and the registered issue port toward the CORDIC.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      y_clamp <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        y_out   <= mem[rd_ptr][19:0];
        y_valid <= 1'b1;
        y_clamp <= mem[rd_ptr][20];
      end else begin
        y_out   <= '0;
        y_valid <= 1'b0;
        y_clamp <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Free-running delay line mirrors the CORDIC pipeline depth for valid/clamp.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        dly[i] <= 2'b00;
      end
    end else begin
      dly[0] <= {y_valid, y_clamp};
      for (int i = 1; i < LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign res_valid   = dly[LATENCY-1][1];
  assign res_clamped = dly[LATENCY-1][0];

`ifdef ATANH_COND_STATS_EN
  logic [7:0] ovr_q;

  // Count accepted clamped samples, saturating; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 8'h00;
    end else if (do_push && in_clamp && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign ovr_cnt = ovr_q;
`else
  assign ovr_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_atanh_input_conditioner.sv
// Testbench for atanh_input_conditioner: directed vectors with hand-computed
// expectations. Stimulus queues expected samples. A negedge monitor checks
// y_out order/content and the res_valid/res_clamped timing and flags.
module tb_atanh_input_conditioner;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [19:0]            in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   issue_en;
  logic                   flush;
  logic [19:0]            y_out;
  logic                   y_valid;
  logic                   res_valid;
  logic                   res_clamped;
  logic [7:0]             ovr_cnt;
  logic [$clog2(DEPTH):0] count;

  atanh_input_conditioner #(
    .DEPTH(DEPTH),
    .LATENCY(LATENCY),
    .YMAX(20'h0FFBE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .issue_en(issue_en),
    .flush(flush),
    .y_out(y_out),
    .y_valid(y_valid),
    .res_valid(res_valid),
    .res_clamped(res_clamped),
    .ovr_cnt(ovr_cnt),
    .count(count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] data;
    logic        clamp;
  } y_exp_t;

  typedef struct {
    int   due;
    logic clamp;
  } r_exp_t;

  y_exp_t y_q[$];
  r_exp_t r_q[$];
  y_exp_t mon_y;
  r_exp_t mon_r;

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  int   exp_ovr = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic failEvent(input string name);
    checks++;
    $display("[TB] FAIL %s: event not as expected at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] expOvr();
`ifdef ATANH_COND_STATS_EN
    return 32'(exp_ovr);
`else
    return 32'(exp_ovr * 0);
`endif
  endfunction

  task automatic queueExpected(input logic [19:0] exp_data, input logic exp_clamp);
    y_exp_t e;
    e.data  = exp_data;
    e.clamp = exp_clamp;
    y_q.push_back(e);
    if (exp_clamp && exp_ovr < 255) exp_ovr++;
  endtask

  // Offer one sample and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [19:0] data, input logic [19:0] exp_data,
                               input logic exp_clamp);
    int guard;
    guard    = 0;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      failEvent("push_timeout");
    end else begin
      queueExpected(exp_data, exp_clamp);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: checks issued samples and their delayed result flags.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (y_valid) begin
        if (y_q.size() == 0) begin
          failEvent("unexpected_y_valid");
        end else begin
          mon_y = y_q.pop_front();
          checkOutput("y_out", {12'h0, y_out}, {12'h0, mon_y.data});
          mon_r.due   = cyc + LATENCY;
          mon_r.clamp = mon_y.clamp;
          r_q.push_back(mon_r);
        end
      end else begin
        checkOutput("idle_y_out", {12'h0, y_out}, 32'h0);
      end
      if (res_valid) begin
        if (r_q.size() == 0) begin
          failEvent("unexpected_res_valid");
        end else begin
          mon_r = r_q.pop_front();
          checkOutput("res_time", 32'(cyc), 32'(mon_r.due));
          checkOutput("res_clamped", {31'h0, res_clamped}, {31'h0, mon_r.clamp});
        end
      end
      while (r_q.size() > 0 && r_q[0].due <= cyc) begin
        failEvent("missing_res_valid");
        void'(r_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [19:0] t2_in  [9] = '{20'h10000, 20'hEFFFF, 20'h0FFBE, 20'hF0042, 20'h0FFFF,
                              20'hF0001, 20'hF0000, 20'h7FFFF, 20'h80000};
  logic [19:0] t2_exp [9] = '{20'h0FFBE, 20'hF0042, 20'h0FFBE, 20'hF0042, 20'h0FFFF,
                              20'hF0001, 20'hF0042, 20'h0FFBE, 20'hF0042};
  logic        t2_clp [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [19:0] t3_in  [5] = '{20'h01111, 20'h02222, 20'h03333, 20'h04444, 20'h05555};
  logic [19:0] t4_in  [10] = '{20'h00301, 20'h00302, 20'h00303, 20'h00304, 20'h00305,
                               20'h00306, 20'h00307, 20'h00308, 20'h00309, 20'h0030A};
  logic [19:0] t5_in  [8] = '{20'h00011, 20'h00022, 20'h00033, 20'h00044, 20'h00055,
                              20'h00066, 20'h00077, 20'h00088};

  initial begin
    int seen;
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    issue_en = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("rst_y_valid", {31'h0, y_valid}, 32'd0);
    checkOutput("rst_res_valid", {31'h0, res_valid}, 32'd0);
    checkOutput("rst_ovr_cnt", {24'h0, ovr_cnt}, 32'd0);

    // Single in-range sample, issued two cycles after its push edge.
    issue_en = 1'b1;
    applyStimulus(20'h0778D, 20'h0778D, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("first_y_valid", {31'h0, y_valid}, 32'd1);
    checkOutput("first_y_out", {12'h0, y_out}, 32'h0778D);
    repeat (LATENCY + 4) @(posedge clk);
    #1;

    // Saturation and the boundaries around +/-1.0 and +/-YMAX.
    for (int i = 0; i < 3; i++) applyStimulus(t2_in[i], t2_exp[i], t2_clp[i]);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovr_after_three", {24'h0, ovr_cnt}, expOvr());
    for (int i = 3; i < 9; i++) applyStimulus(t2_in[i], t2_exp[i], t2_clp[i]);
    repeat (LATENCY + 4) @(posedge clk);
    #1;
    checkOutput("ovr_after_bounds", {24'h0, ovr_cnt}, expOvr());

    // Fill to full with issue disabled; the fifth sample waits.
    issue_en = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(t3_in[i], t3_in[i], 1'b0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_in_ready", {31'h0, in_ready}, 32'd0);
    in_data  = t3_in[4];
    in_valid = 1'b1;
    queueExpected(t3_in[4], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_count", 32'(count), 32'd4);
    checkOutput("held_in_ready", {31'h0, in_ready}, 32'd0);
    issue_en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("drain1_count", 32'(count), 32'd3);
    checkOutput("drain1_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("drain1_y_valid", {31'h0, y_valid}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("drain2_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("drain_y_valid", {31'h0, y_valid}, 32'd1);
    end
    checkOutput("drained_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("drained_y_valid", {31'h0, y_valid}, 32'd0);
    repeat (LATENCY + 4) @(posedge clk);
    #1;

    // Steady push+pop at occupancy 2; pointers wrap several times.
    issue_en = 1'b0;
    applyStimulus(20'h00100, 20'h00100, 1'b0);
    applyStimulus(20'h00200, 20'h00200, 1'b0);
    issue_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data  = t4_in[i];
      in_valid = 1'b1;
      queueExpected(t4_in[i], 1'b0);
      @(posedge clk);
      #1;
      checkOutput("stream_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    repeat (LATENCY + 6) @(posedge clk);
    #1;

    // Reset with samples both queued and in flight.
    issue_en = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(t5_in[i], t5_in[i], 1'b0);
    @(posedge clk);
    #1;
    issue_en = 1'b0;
    for (int i = 5; i < 8; i++) applyStimulus(t5_in[i], t5_in[i], 1'b0);
    checkOutput("prereset_count", 32'(count), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    y_q.delete();
    r_q.delete();
    exp_ovr = 0;
    checkOutput("postreset_count", 32'(count), 32'd0);
    checkOutput("postreset_y_valid", {31'h0, y_valid}, 32'd0);
    checkOutput("postreset_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("postreset_ovr", {24'h0, ovr_cnt}, 32'd0);
    seen = 0;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    checkOutput("postreset_res_pulses", 32'(seen), 32'd0);

    // Flush with a same-cycle push at occupancy 1.
    @(posedge clk);
    #1;
    issue_en = 1'b0;
    applyStimulus(20'h7FFFF, 20'h0FFBE, 1'b1);
    checkOutput("preflush_count", 32'(count), 32'd1);
    in_data  = 20'h40000;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    y_q.delete();
    r_q.delete();
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_ovr", {24'h0, ovr_cnt}, expOvr());
    checkOutput("flush_y_valid", {31'h0, y_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'h0, in_ready}, 32'd1);
    issue_en = 1'b1;
    applyStimulus(20'h00ABC, 20'h00ABC, 1'b0);
    repeat (LATENCY + 6) @(posedge clk);
    #1;

    checkOutput("y_queue_empty", 32'(y_q.size()), 32'd0);
    checkOutput("res_queue_empty", 32'(r_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/atanh_input_conditioner.md
Name: atanh_input_conditioner

Overview:
- Upstream stage of cordic_tanh_inverse. Accepts raw Q4.16 samples over a valid/ready handshake and buffers them in a small FIFO.
- Range-checks and saturates each sample into the atanh domain (-1,1), then issues one sample per cycle on the CORDIC `y_input` bus.
- Runs a latency-matched valid/flag delay line so downstream logic knows which cycle's `z_res` is valid and whether it came from a clamped input.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- LATENCY, 16, cycles from `y_valid` to matching `z_res` at CORDIC output; ≥1.
- YMAX, 20'h0FFBE, positive saturation magnitude in Q4.16 (≈0.999); negative clamp is -YMAX = 20'hF0042.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_data  input  20  signed Q4.16 sample
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept
- issue_en  input  1  permit popping FIFO toward CORDIC
- flush  input  1  synchronous clear of FIFO and delay line
- y_out  output  20  signed Q4.16 to CORDIC `y_input`
- y_valid  output  1  y_out holds an issued sample this cycle
- res_valid  output  1  CORDIC `z_res` this cycle corresponds to an issued sample
- res_clamped  output  1  that sample was saturated
- ovr_cnt  output  8  count of clamped samples (optional feature)
- count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, taking effect on the clock edge while rst=1:
  - y_out=0, y_valid=0, res_valid=0, res_clamped=0, ovr_cnt=0, count=0.
  - FIFO pointers are 0 and the delay line is all zeros.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards queued and in-flight samples; no res_valid pulses follow the reset.
- Accept:
  - Push on an edge where in_valid & in_ready.
  - in_ready = (count != DEPTH). It is purely occupancy-based; a same-cycle pop does not raise it when full.
- Range check at push time, on the signed 20-bit value:
  - in_data ≥ 20'h10000 (≥ +1.0): store YMAX, clamp flag 1.
  - in_data ≤ 20'hF0000 (≤ -1.0): store -YMAX, clamp flag 1.
  - Otherwise store unchanged, flag 0.
  - Exactly ±YMAX passes unclamped.
  - The FIFO entry is 21 bits: data plus flag.
- Issue:
  - Pop on an edge where issue_en & (count != 0).
  - y_out and y_valid are registered and update on the pop edge, so data is visible the cycle after the pop.
  - On an edge with no pop: y_valid goes to 0 and y_out goes to 0. This keeps the CORDIC pipeline fed with a benign value.
- Latency: a sample pushed at edge N is at the earliest popped at edge N+1, giving y_valid in the cycle after N+1. The FIFO is not fall-through.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged.
- Simultaneous push and pop at count=0: push only. The pop needs count != 0.
- Pointers wrap modulo DEPTH.
- Delay line:
  - LATENCY-deep shift register of {y_valid, clamp flag}.
  - Its output drives res_valid and res_clamped, which therefore assert exactly LATENCY cycles after the corresponding y_valid.
  - Shifts every cycle unconditionally; it is not stalled by issue_en.
- Flush:
  - Same effect as reset on the FIFO, y_out/y_valid and the delay line.
  - ovr_cnt is preserved.
  - Flush has priority over a same-cycle push or pop; the pushed sample is dropped.
- No state machine beyond pointers and counters. Behaviour is fully defined by count, pointers and the delay line.

Optional Feature:
- Macro: ATANH_COND_STATS_EN.
- Defined:
  - ovr_cnt increments on each accepted push whose clamp flag is 1.
  - It saturates at 8'hFF and is cleared only by rst.
- Undefined: the counter logic is omitted and ovr_cnt is tied to 8'h00.

Test Plan:
- Push 0x0778D (0.467) with issue_en=1 → y_out=0x0778D and y_valid=1 two cycles after the push edge. LATENCY cycles later: res_valid=1, res_clamped=0.
- Push 0x10000, then 0xEFFFF, then 0x0FFBE → y_out sequence 0x0FFBE, 0xF0042, 0x0FFBE with res_clamped 1,1,0. With the macro defined, ovr_cnt=2.
- issue_en=0, offer 5 back-to-back samples → 4 accepted, in_ready=0 while count=4, 5th held. Raise issue_en → 5th accepted; outputs come out in order, one per cycle.
- Continuous push and pop with count=2 for 10 cycles → count stays 2, no loss or duplication, pointers wrap correctly.
- Assert rst for 1 cycle with 3 queued and 5 in flight → next cycle count=0 and y_valid=0, and no res_valid for the following LATENCY+4 cycles.
- Assert flush together with in_valid at count=1 → count=0, sample dropped, ovr_cnt unchanged.
